score_display: RTL and testbench

- Parametrised successor to the fixed four-digit score overlay in the game screen.
- Holds an N-digit BCD score and adds line-clear points through a valid/ready handshake, using a digit-serial BCD adder.
- Renders the committed score as seven-segment glyphs for the VGA pixel stream.
- game_screen ORs pix_on/pix_in_box into colour_calc (white/background), replacing the hard-wired segment7 instances.

---
 rtl/score_display.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_score_display.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/score_display.sv
// -----------------------------------------------------------------------------
// score_display
//
// Purpose:
//   Holds an N-digit BCD game score. Line-clear points are added through a
//   valid/ready handshake using a digit-serial BCD adder, one digit per
//   clock. The committed score is drawn as seven-segment glyphs for the VGA
//   pixel stream. game_screen ORs pix_on / pix_in_box into its colour logic.
//
// Handshake:
//   A request transfers on a rising clk edge where add_valid && add_ready are
//   both high and clear is low. add_ready is high only in IDLE. The master
//   holds add_valid and add_lines stable until the transfer. A request that
//   is pending while clear is high is discarded, not queued.
//
// Ports:
//   clk         in   system clock
//   resetn      in   synchronous active-low reset
//   clear       in   synchronous score clear (new game), highest priority
//   add_valid   in   points request valid
//   add_lines   in   [2:0] lines cleared by this request
//   add_ready   out  block can accept a request (IDLE only)
//   x, y        in   [9:0] current VGA pixel column / row
//   pix_in_box  out  registered: pixel lies inside some digit box
//   pix_on      out  registered: pixel lies on a lit, unblanked segment
//   score_bcd   out  [4*DIGITS-1:0] committed score, MSD in top nibble
//   overflow    out  sticky: score saturated at all nines
//   dbg_state   out  [1:0] FSM state (0=IDLE, 1=ADD, 2=COMMIT)
// -----------------------------------------------------------------------------
module score_display #(
    parameter int DIGITS   = 4,
    parameter int X0       = 50,
    parameter int Y0       = 139,
    parameter int DIGIT_W  = 20,
    parameter int PITCH    = 25,
    parameter int SEG_T    = 5,
    parameter int SEG_H    = 7,
    parameter int BLANK_LZ = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  clear,
    input  logic                  add_valid,
    input  logic [2:0]            add_lines,
    output logic                  add_ready,
    input  logic [9:0]            x,
    input  logic [9:0]            y,
    output logic                  pix_in_box,
    output logic                  pix_on,
    output logic [4*DIGITS-1:0]   score_bcd,
    output logic                  overflow,
    output logic [1:0]            dbg_state
);

    localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [4*DIGITS-1:0] NINES = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ADD    = 2'd1,
        S_COMMIT = 2'd2
    } state_e;

    // Segment bit order: [6]=a [5]=b [4]=c [3]=d [2]=e [1]=f [0]=g
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] points_of(input logic [2:0] lines);
        logic [3:0] p;
        case (lines)
            3'd1:    p = 4'd1;
            3'd2:    p = 4'd3;
            3'd3:    p = 4'd5;
            3'd4:    p = 4'd8;
            default: p = 4'd0;
        endcase
        return p;
    endfunction

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_e                    state_q, state_d;
    logic [DIGITS-1:0][3:0]    work_q, work_d;
    logic [DIGITS-1:0][3:0]    score_q, score_d;
    logic                      ovf_q, ovf_d;
    logic [KW-1:0]             k_q, k_d;
    logic                      carry_q, carry_d;
    logic [3:0]                pts_q, pts_d;
    logic                      pix_on_q, pix_on_d;
    logic                      pix_box_q, pix_box_d;

    logic                      accept;
    logic                      add_step;
    logic                      commit;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (add_valid) state_d = S_ADD;
                end
                S_ADD: begin
                    if (k_q == KW'(DIGITS - 1)) state_d = S_COMMIT;
                end
                S_COMMIT: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs and datapath strobes
    // ------------------------------------------------------------------
    always_comb begin
        add_ready = (state_q == S_IDLE);
        dbg_state = state_q;
        accept    = (state_q == S_IDLE) && add_valid && !clear;
        add_step  = (state_q == S_ADD);
        commit    = (state_q == S_COMMIT);
    end

    // ------------------------------------------------------------------
    // Digit-serial BCD adder and commit
    // ------------------------------------------------------------------
    logic [4:0] sum;
    logic [4:0] sum_m10;

    always_comb begin
        work_d  = work_q;
        score_d = score_q;
        ovf_d   = ovf_q;
        k_d     = k_q;
        carry_d = carry_q;
        pts_d   = pts_q;
        // Points enter only at the units digit; higher digits see carry only.
        sum     = {1'b0, work_q[k_q]}
                + ((k_q == '0) ? {1'b0, pts_q} : 5'd0)
                + {4'd0, carry_q};
        sum_m10 = sum - 5'd10;

        if (clear) begin
            work_d  = '0;
            score_d = '0;
            ovf_d   = 1'b0;
            k_d     = '0;
            carry_d = 1'b0;
        end else if (accept) begin
            pts_d   = points_of(add_lines);
            k_d     = '0;
            carry_d = 1'b0;
        end else if (add_step) begin
            if (sum > 5'd9) begin
                work_d[k_q] = sum_m10[3:0];
                carry_d     = 1'b1;
            end else begin
                work_d[k_q] = sum[3:0];
                carry_d     = 1'b0;
            end
            k_d = k_q + KW'(1);
        end else if (commit) begin
            // A carry out of the MSD saturates the score; it stays sticky
            // because 9...9 plus any nonzero points carries out again.
            if (carry_q) begin
                work_d  = NINES;
                score_d = NINES;
                ovf_d   = 1'b1;
            end else begin
                score_d = work_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            work_q  <= '0;
            score_q <= '0;
            ovf_q   <= 1'b0;
            k_q     <= '0;
            carry_q <= 1'b0;
            pts_q   <= '0;
        end else begin
            work_q  <= work_d;
            score_q <= score_d;
            ovf_q   <= ovf_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            pts_q   <= pts_d;
        end
    end

    assign score_bcd = score_q;
    assign overflow  = ovf_q;

    // ------------------------------------------------------------------
    // Renderer: uses the committed score only, so a glyph never shows a
    // partially added value.
    // ------------------------------------------------------------------
    int         xi, yi;
    int         left_c, right_c;
    logic [3:0] digit_c;
    logic [6:0] segs_c;
    logic       zero_run_c;
    logic       blank_c;
    logic       in_x_c, in_y_c;
    logic       col_l_c, col_r_c;
    logic       band_a_c, band_u_c, band_g_c, band_l_c, band_d_c;
    logic       lit_c;

    always_comb begin
        xi         = {22'd0, x};
        yi         = {22'd0, y};
        pix_box_d  = 1'b0;
        pix_on_d   = 1'b0;
        zero_run_c = 1'b1;
        left_c     = 0;
        right_c    = 0;
        digit_c    = '0;
        segs_c     = '0;
        blank_c    = 1'b0;
        in_x_c     = 1'b0;
        in_y_c     = 1'b0;
        col_l_c    = 1'b0;
        col_r_c    = 1'b0;
        band_a_c   = 1'b0;
        band_u_c   = 1'b0;
        band_g_c   = 1'b0;
        band_l_c   = 1'b0;
        band_d_c   = 1'b0;
        lit_c      = 1'b0;
        // i walks from the MSD (leftmost) towards the units digit so that
        // zero_run tracks "this and every more-significant digit is zero".
        for (int i = 0; i < DIGITS; i++) begin
            left_c     = X0 + i * PITCH;
            right_c    = left_c + DIGIT_W - 1;
            digit_c    = score_q[DIGITS-1-i];
            segs_c     = seg7(digit_c);
            zero_run_c = zero_run_c && (digit_c == 4'd0);
            blank_c    = (BLANK_LZ != 0) && (i < DIGITS - 1) && zero_run_c;

            in_x_c   = (xi >= left_c) && (xi <= right_c);
            in_y_c   = (yi >= Y0) && (yi <= Y0 + 5 * SEG_H - 1);
            col_l_c  = (xi <= left_c + SEG_T - 1);
            col_r_c  = (xi >= right_c - SEG_T + 1);
            band_a_c = (yi >= Y0)             && (yi < Y0 + SEG_H);
            band_u_c = (yi >= Y0 + SEG_H)     && (yi < Y0 + 2 * SEG_H);
            band_g_c = (yi >= Y0 + 2 * SEG_H) && (yi < Y0 + 3 * SEG_H);
            band_l_c = (yi >= Y0 + 3 * SEG_H) && (yi < Y0 + 4 * SEG_H);
            band_d_c = (yi >= Y0 + 4 * SEG_H) && (yi < Y0 + 5 * SEG_H);

            lit_c = (band_a_c && segs_c[6])
                  || (band_u_c && col_r_c && segs_c[5])
                  || (band_l_c && col_r_c && segs_c[4])
                  || (band_d_c && segs_c[3])
                  || (band_l_c && col_l_c && segs_c[2])
                  || (band_u_c && col_l_c && segs_c[1])
                  || (band_g_c && segs_c[0]);

            if (in_x_c && in_y_c) begin
                pix_box_d = 1'b1;
                if (lit_c && !blank_c) pix_on_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pix_on_q  <= 1'b0;
            pix_box_q <= 1'b0;
        end else begin
            pix_on_q  <= pix_on_d;
            pix_box_q <= pix_box_d;
        end
    end

    assign pix_on     = pix_on_q;
    assign pix_in_box = pix_box_q;

endmodule

// File: tb/tb_score_display.sv
module tb_score_display;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  // ---------------------------------------------------------------
  // clock / reset
  // ---------------------------------------------------------------
  logic         clk;
  logic         resetn;
  logic         clear;
  logic         add_valid;
  logic [2:0]   add_lines;
  logic         add_ready;
  logic [9:0]   x;
  logic [9:0]   y;
  logic         pix_in_box;
  logic         pix_on;
  logic [W-1:0] score_bcd;
  logic         overflow;
  logic [1:0]   dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  score_display #(
    .DIGITS(DIGITS), .X0(50), .Y0(139), .DIGIT_W(20), .PITCH(25),
    .SEG_T(5), .SEG_H(7), .BLANK_LZ(1)
  ) dut (
    .clk(clk), .resetn(resetn), .clear(clear),
    .add_valid(add_valid), .add_lines(add_lines), .add_ready(add_ready),
    .x(x), .y(y), .pix_in_box(pix_in_box), .pix_on(pix_on),
    .score_bcd(score_bcd), .overflow(overflow), .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------
  // scoreboard
  // ---------------------------------------------------------------
  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------
  // driver tasks
  // ---------------------------------------------------------------
  // Present a pixel, then sample right after the next edge: a one-cycle
  // render latency is the only way to see this pixel's value there.
  task automatic pix(input string tag, input logic [9:0] px, input logic [9:0] py,
                     input logic exp_box, input logic exp_on);
    @(negedge clk);
    x = px;
    y = py;
    @(posedge clk);
    #1;
    check({tag, "_box"}, {31'd0, pix_in_box}, {31'd0, exp_box});
    check({tag, "_on"},  {31'd0, pix_on},     {31'd0, exp_on});
  endtask

  // One request; checks busy length, old score held through COMMIT,
  // new score and overflow once ready returns.
  task automatic do_add(input string tag, input logic [2:0] lines,
                        input logic [W-1:0] exp_score, input logic exp_ovf);
    logic [W-1:0] old_score;
    logic [W-1:0] last_score;
    int           lows;
    exp_q.push_back(exp_score);
    @(negedge clk);
    check({tag, "_rdy"}, {31'd0, add_ready}, 32'd1);
    old_score = score_bcd;
    add_valid = 1'b1;
    add_lines = lines;
    @(negedge clk);
    add_valid  = 1'b0;
    lows       = 0;
    last_score = score_bcd;
    while (add_ready !== 1'b1 && lows < 40) begin
      last_score = score_bcd;
      lows++;
      @(negedge clk);
    end
    check({tag, "_busy"},  lows, DIGITS + 1);
    check({tag, "_hold"},  {{(32-W){1'b0}}, last_score}, {{(32-W){1'b0}}, old_score});
    check({tag, "_score"}, {{(32-W){1'b0}}, score_bcd},  {{(32-W){1'b0}}, exp_q.pop_front()});
    check({tag, "_ovf"},   {31'd0, overflow}, {31'd0, exp_ovf});
  endtask

  task automatic quiet_add(input logic [2:0] lines);
    int lows;
    @(negedge clk);
    add_valid = 1'b1;
    add_lines = lines;
    @(negedge clk);
    add_valid = 1'b0;
    lows = 0;
    while (add_ready !== 1'b1 && lows < 40) begin
      lows++;
      @(negedge clk);
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  // ---------------------------------------------------------------
  // stimulus
  // ---------------------------------------------------------------
  initial begin
    resetn    = 1'b0;
    clear     = 1'b0;
    add_valid = 1'b0;
    add_lines = 3'd0;
    x         = 10'd125;
    y         = 10'd141;

    // reset: render registers held low even with an in-box pixel
    repeat (3) @(negedge clk);
    check("rst_on",    {31'd0, pix_on},     32'd0);
    check("rst_box",   {31'd0, pix_in_box}, 32'd0);
    check("rst_state", {30'd0, dbg_state},  32'd0);
    resetn = 1'b1;
    @(negedge clk);
    check("idle_rdy",   {31'd0, add_ready}, 32'd1);
    check("idle_score", {16'd0, score_bcd}, 32'h0000);
    check("idle_ovf",   {31'd0, overflow},  32'd0);

    // score 0000: only the units "0" drawn
    pix("z_units_a", 10'd125, 10'd141, 1'b1, 1'b1);
    pix("z_msd_a",   10'd50,  10'd141, 1'b1, 1'b0);
    pix("z_gap",     10'd70,  10'd141, 1'b0, 1'b0);
    pix("z_units_g", 10'd130, 10'd156, 1'b1, 1'b0);

    // 8 + 8 with BCD carry
    do_add("add8a", 3'd4, 16'h0008, 1'b0);
    do_add("add8b", 3'd4, 16'h0016, 1'b0);

    // score 0016 rendering
    pix("s_tens_g",   10'd100, 10'd156, 1'b1, 1'b0);
    pix("s_units_g",  10'd125, 10'd156, 1'b1, 1'b1);
    pix("s_tens_b",   10'd115, 10'd150, 1'b1, 1'b1);
    pix("s_tens_f",   10'd100, 10'd150, 1'b1, 1'b0);
    pix("s_units_f",  10'd125, 10'd150, 1'b1, 1'b1);
    pix("s_units_mid",10'd130, 10'd150, 1'b1, 1'b0);
    pix("s_hund_a",   10'd75,  10'd141, 1'b1, 1'b0);
    pix("s_below",    10'd125, 10'd174, 1'b0, 1'b0);
    pix("s_units_d",  10'd144, 10'd173, 1'b1, 1'b1);

    // zero-point requests
    do_add("add_l0", 3'd0, 16'h0016, 1'b0);
    do_add("add_l6", 3'd6, 16'h0016, 1'b0);
    do_add("add_l2", 3'd2, 16'h0019, 1'b0);
    do_add("add_l3", 3'd3, 16'h0024, 1'b0);

    // preload 9995 then saturate
    do_clear();
    @(negedge clk);
    check("clr_score", {16'd0, score_bcd}, 32'h0000);
    for (int i = 0; i < 1249; i++) quiet_add(3'd4);
    quiet_add(3'd2);
    @(negedge clk);
    check("pre_score", {16'd0, score_bcd}, 32'h9995);
    do_add("sat",     3'd4, 16'h9999, 1'b1);
    do_add("sat_more",3'd1, 16'h9999, 1'b1);

    // clear in cycle 2 of an ADD pass with add_valid held
    @(negedge clk);
    add_valid = 1'b1;
    add_lines = 3'd1;
    @(negedge clk);
    @(negedge clk);
    check("mid_state", {30'd0, dbg_state}, 32'd1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr_state", {30'd0, dbg_state}, 32'd0);
    check("clr_sc2",   {16'd0, score_bcd}, 32'h0000);
    check("clr_ovf",   {31'd0, overflow},  32'd0);
    check("clr_rdy",   {31'd0, add_ready}, 32'd1);
    @(negedge clk);
    check("held_acc",  {30'd0, dbg_state}, 32'd1);
    add_valid = 1'b0;
    for (int i = 0; i < 40 && add_ready !== 1'b1; i++) @(negedge clk);
    check("held_score", {16'd0, score_bcd}, 32'h0001);
    check("held_ovf",   {31'd0, overflow},  32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
